// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline feedback control. Detects load-use, redirect and
// data-memory wait hazards, drives stall/flush commands to PC, IF/ID and
// ID/EX, and selects EX/MEM forwarding for the EX-stage ALU operands.
// Multi-cycle flushes and bubbles are sequenced by a small FSM; a memory
// wait freezes that FSM and resumes it where it left off.
module hazard_ctrl #(
  parameter int REG_AW       = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int LU_BUBBLES   = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_addr_ID,
  input  logic [REG_AW-1:0] rt_addr_ID,
  input  logic              use_rs_ID,
  input  logic              use_rt_ID,
  input  logic [REG_AW-1:0] addr3_EX,
  input  logic              wite_reg_EX,
  input  logic              read_mem_EX,
  input  logic [1:0]        jp_flag_EX,
  input  logic              branch_taken_EX,
  input  logic [REG_AW-1:0] addr3_MEM,
  input  logic              wite_reg_MEM,
  input  logic              read_mem_MEM,
  input  logic              mem_ready,
  output logic              stall_PC,
  output logic              stall_IFID,
  output logic              stall_IDEX,
  output logic              flush_IFID,
  output logic              flush_IDEX,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [1:0]        hz_state,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] S_RUN   = 2'b00;
  localparam logic [1:0] S_FLUSH = 2'b01;
  localparam logic [1:0] S_LU    = 2'b10;
  localparam logic [1:0] S_MW    = 2'b11;

  localparam logic [2:0] FL_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] LU_INIT = 3'(LU_BUBBLES - 1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [1:0]       sav_state_q, sav_state_d;
  logic [2:0]       sav_cnt_q, sav_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic redirect, luse, mwait;
  logic rs_nz, rt_nz;
  logic [1:0] eff_state;
  logic [2:0] eff_cnt;
  logic s_pc, s_ifid, s_idex, f_ifid, f_idex;
  logic [1:0] fa, fb;

  assign rs_nz    = (rs_addr_ID != '0);
  assign rt_nz    = (rt_addr_ID != '0);
  // Reserved jp_flag 11 falls through as "no jump".
  assign redirect = (jp_flag_EX == 2'b01) | ((jp_flag_EX == 2'b10) & branch_taken_EX);
  assign luse     = read_mem_EX & wite_reg_EX & (addr3_EX != '0) &
                    ((use_rs_ID & rs_nz & (rs_addr_ID == addr3_EX)) |
                     (use_rt_ID & rt_nz & (rt_addr_ID == addr3_EX)));
  assign mwait    = read_mem_MEM & ~mem_ready;

  // In MEM_WAIT the frozen sequence is what drives behaviour once mwait drops.
  assign eff_state = (state_q == S_MW) ? sav_state_q : state_q;
  assign eff_cnt   = (state_q == S_MW) ? sav_cnt_q   : cnt_q;

  // Command generation and next-state; priority mwait > redirect > luse.
  always_comb begin
    s_pc        = 1'b0;
    s_ifid      = 1'b0;
    s_idex      = 1'b0;
    f_ifid      = 1'b0;
    f_idex      = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    sav_state_d = sav_state_q;
    sav_cnt_d   = sav_cnt_q;
    if (mwait) begin
      s_pc    = 1'b1;
      s_ifid  = 1'b1;
      s_idex  = 1'b1;
      state_d = S_MW;
      // Only capture on entry; staying in MEM_WAIT keeps the original snapshot.
      if (state_q != S_MW) begin
        sav_state_d = state_q;
        sav_cnt_d   = cnt_q;
      end
    end else begin
      case (eff_state)
        S_RUN, S_LU: begin
          if (redirect) begin
            f_ifid = 1'b1;
            f_idex = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = S_FLUSH;
              cnt_d   = FL_INIT;
            end else begin
              state_d = S_RUN;
              cnt_d   = 3'd0;
            end
          end else if (eff_state == S_LU) begin
            s_pc   = 1'b1;
            s_ifid = 1'b1;
            f_idex = 1'b1;
            if (eff_cnt <= 3'd1) begin
              state_d = S_RUN;
              cnt_d   = 3'd0;
            end else begin
              state_d = S_LU;
              cnt_d   = eff_cnt - 3'd1;
            end
          end else if (luse) begin
            s_pc   = 1'b1;
            s_ifid = 1'b1;
            f_idex = 1'b1;
            if (LU_BUBBLES > 1) begin
              state_d = S_LU;
              cnt_d   = LU_INIT;
            end else begin
              state_d = S_RUN;
              cnt_d   = 3'd0;
            end
          end else begin
            state_d = S_RUN;
            cnt_d   = 3'd0;
          end
        end
        S_FLUSH: begin
          // EX only holds bubbles here, so redirect is not looked at.
          f_ifid = 1'b1;
          f_idex = 1'b1;
          if (eff_cnt <= 3'd1) begin
            state_d = S_RUN;
            cnt_d   = 3'd0;
          end else begin
            state_d = S_FLUSH;
            cnt_d   = eff_cnt - 3'd1;
          end
        end
        default: begin
          state_d = S_RUN;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // Operand forwarding; EX beats MEM, loads in EX have no result yet.
  always_comb begin
    fa = 2'b00;
    fb = 2'b00;
    if (wite_reg_EX & ~read_mem_EX & rs_nz & (addr3_EX == rs_addr_ID))
      fa = 2'b01;
    else if (wite_reg_MEM & rs_nz & (addr3_MEM == rs_addr_ID))
      fa = 2'b10;
    if (wite_reg_EX & ~read_mem_EX & rt_nz & (addr3_EX == rt_addr_ID))
      fb = 2'b01;
    else if (wite_reg_MEM & rt_nz & (addr3_MEM == rt_addr_ID))
      fb = 2'b10;
  end

  // Output gating: everything quiet while reset is held.
  always_comb begin
    stall_PC   = s_pc   & ~reset;
    stall_IFID = s_ifid & ~reset;
    stall_IDEX = s_idex & ~reset;
    flush_IFID = f_ifid & ~reset;
    flush_IDEX = f_idex & ~reset;
    fwd_a_sel  = reset ? 2'b00 : fa;
    fwd_b_sel  = reset ? 2'b00 : fb;
  end

  assign hz_state  = state_q;
  assign stall_cnt = stall_cnt_q;

  // FSM registers and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      cnt_q       <= 3'd0;
      sav_state_q <= S_RUN;
      sav_cnt_q   <= 3'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sav_state_q <= sav_state_d;
      sav_cnt_q   <= sav_cnt_d;
      if (stall_PC && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl. Two instances share the stimulus:
// u0 uses LU_BUBBLES=1, u1 uses LU_BUBBLES=3; each expectation names the
// instance it applies to. The driver pushes hand-computed expectations,
// the monitor pops and compares on the falling edge.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [2:0] rs, rt;
    logic       urs, urt;
    logic [2:0] a3e;
    logic       wre, rme;
    logic [1:0] jp;
    logic       bt;
    logic [2:0] a3m;
    logic       wrm, rmm, mr;
  } in_t;

  typedef struct {
    int          dut;
    logic [4:0]  ctl;   // {stall_PC, stall_IFID, stall_IDEX, flush_IFID, flush_IDEX}
    logic [1:0]  fa, fb, st;
    bit          csc;
    logic [15:0] sc;
    string       name;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t  vin;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  logic [4:0]  ctl_o [2];
  logic [1:0]  fa_o [2], fb_o [2], st_o [2];
  logic [15:0] sc_o [2];

  hazard_ctrl #(.REG_AW(3), .FLUSH_CYCLES(2), .LU_BUBBLES(1), .CNT_W(16)) u0 (
    .clk(clk), .reset(vin.rst),
    .rs_addr_ID(vin.rs), .rt_addr_ID(vin.rt), .use_rs_ID(vin.urs), .use_rt_ID(vin.urt),
    .addr3_EX(vin.a3e), .wite_reg_EX(vin.wre), .read_mem_EX(vin.rme),
    .jp_flag_EX(vin.jp), .branch_taken_EX(vin.bt),
    .addr3_MEM(vin.a3m), .wite_reg_MEM(vin.wrm), .read_mem_MEM(vin.rmm), .mem_ready(vin.mr),
    .stall_PC(ctl_o[0][4]), .stall_IFID(ctl_o[0][3]), .stall_IDEX(ctl_o[0][2]),
    .flush_IFID(ctl_o[0][1]), .flush_IDEX(ctl_o[0][0]),
    .fwd_a_sel(fa_o[0]), .fwd_b_sel(fb_o[0]), .hz_state(st_o[0]), .stall_cnt(sc_o[0])
  );

  hazard_ctrl #(.REG_AW(3), .FLUSH_CYCLES(2), .LU_BUBBLES(3), .CNT_W(16)) u1 (
    .clk(clk), .reset(vin.rst),
    .rs_addr_ID(vin.rs), .rt_addr_ID(vin.rt), .use_rs_ID(vin.urs), .use_rt_ID(vin.urt),
    .addr3_EX(vin.a3e), .wite_reg_EX(vin.wre), .read_mem_EX(vin.rme),
    .jp_flag_EX(vin.jp), .branch_taken_EX(vin.bt),
    .addr3_MEM(vin.a3m), .wite_reg_MEM(vin.wrm), .read_mem_MEM(vin.rmm), .mem_ready(vin.mr),
    .stall_PC(ctl_o[1][4]), .stall_IFID(ctl_o[1][3]), .stall_IDEX(ctl_o[1][2]),
    .flush_IFID(ctl_o[1][1]), .flush_IDEX(ctl_o[1][0]),
    .fwd_a_sel(fa_o[1]), .fwd_b_sel(fb_o[1]), .hz_state(st_o[1]), .stall_cnt(sc_o[1])
  );

  // Monitor: every expectation is for the cycle it was issued in.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      int   d;
      bit   bad;
      e = q.pop_front();
      d = e.dut;
      n_tests++;
      bad = (e.cyc != cyc) || (ctl_o[d] !== e.ctl) || (fa_o[d] !== e.fa) ||
            (fb_o[d] !== e.fb) || (st_o[d] !== e.st) || (e.csc && (sc_o[d] !== e.sc));
      if (bad) begin
        n_fail++;
        $display("FAIL %s (u%0d cyc %0d): got ctl=%b fa=%b fb=%b st=%b sc=%h, want ctl=%b fa=%b fb=%b st=%b sc=%h%s",
                 e.name, d, cyc, ctl_o[d], fa_o[d], fb_o[d], st_o[d], sc_o[d],
                 e.ctl, e.fa, e.fb, e.st, e.sc, e.csc ? "" : "(unchecked)");
      end
    end
  end

  function automatic in_t idle();
    in_t v;
    v    = '0;
    v.mr = 1'b1;
    return v;
  endfunction

  task automatic drive(input in_t v);
    @(posedge clk);
    #1;
    vin = v;
  endtask

  task automatic chk(input in_t v, input int d, input logic [4:0] ctl,
                     input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] st,
                     input bit csc, input logic [15:0] sc, input string nm);
    exp_t e;
    drive(v);
    e.dut = d; e.ctl = ctl; e.fa = fa; e.fb = fb; e.st = st;
    e.csc = csc; e.sc = sc; e.name = nm; e.cyc = cyc;
    q.push_back(e);
  endtask

  // Two reset cycles; the second checks quiet outputs and cleared state.
  task automatic do_reset(input int d);
    in_t v;
    v = idle();
    v.rst = 1'b1;
    drive(v);
    chk(v, d, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b1, 16'h0, "reset_state");
  endtask

  in_t v;

  initial begin
    vin = idle();
    vin.rst = 1'b1;

    // Load-use, single bubble, then MEM forwarding
    do_reset(0);
    v = idle(); v.rme = 1; v.wre = 1; v.a3e = 3; v.rs = 3; v.urs = 1;
    chk(v, 0, 5'b11001, 2'b00, 2'b00, 2'b00, 1'b1, 16'd0, "luse_bubble");
    v = idle(); v.a3m = 3; v.wrm = 1; v.rmm = 1; v.rs = 3; v.urs = 1;
    chk(v, 0, 5'b00000, 2'b10, 2'b00, 2'b00, 1'b1, 16'd1, "luse_after_fwd_mem");

    // Taken branch -> two flush cycles; not-taken and reserved -> nothing
    do_reset(0);
    v = idle(); v.jp = 2'b10; v.bt = 1;
    chk(v, 0, 5'b00011, 2'b00, 2'b00, 2'b00, 1'b0, 16'd0, "br_taken_c1");
    chk(idle(), 0, 5'b00011, 2'b00, 2'b00, 2'b01, 1'b0, 16'd0, "br_taken_c2");
    chk(idle(), 0, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b0, 16'd0, "br_done");
    v = idle(); v.jp = 2'b10; v.bt = 0;
    chk(v, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b0, 16'd0, "br_not_taken");
    v = idle(); v.jp = 2'b11; v.bt = 1;
    chk(v, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b0, 16'd0, "jp_reserved");
    chk(idle(), 0, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b1, 16'd0, "br_no_stall_cnt");

    // Forwarding priority and register-0 masking
    do_reset(0);
    v = idle(); v.a3e = 5; v.wre = 1; v.a3m = 5; v.wrm = 1; v.rmm = 1; v.rt = 5; v.urt = 1;
    chk(v, 0, 5'b00000, 2'b00, 2'b01, 2'b00, 1'b0, 16'd0, "fwd_b_ex_prio");
    v = idle(); v.a3e = 0; v.wre = 1; v.a3m = 0; v.wrm = 1; v.rmm = 1; v.rt = 0; v.urt = 1;
    chk(v, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b0, 16'd0, "fwd_b_r0");
    v = idle(); v.a3e = 0; v.wre = 1; v.rme = 1; v.rs = 0; v.urs = 1;
    chk(v, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b0, 16'd0, "luse_r0_ignored");
    v = idle(); v.a3e = 5; v.wre = 0; v.a3m = 5; v.wrm = 1; v.rs = 5; v.urs = 1;
    chk(v, 0, 5'b00000, 2'b10, 2'b00, 2'b00, 1'b0, 16'd0, "fwd_a_mem_only");
    v = idle(); v.a3e = 5; v.wre = 1; v.rme = 1; v.a3m = 5; v.wrm = 1; v.rt = 5; v.urt = 1;
    chk(v, 0, 5'b11001, 2'b00, 2'b10, 2'b00, 1'b0, 16'd0, "luse_rt_fwd_mem");

    // Memory wait during FLUSH freezes then resumes the remaining cycle
    do_reset(0);
    v = idle(); v.jp = 2'b01;
    chk(v, 0, 5'b00011, 2'b00, 2'b00, 2'b00, 1'b0, 16'd0, "jmp_c1");
    v = idle(); v.rmm = 1; v.mr = 0;
    chk(v, 0, 5'b11100, 2'b00, 2'b00, 2'b01, 1'b1, 16'd0, "mw_in_flush_1");
    chk(v, 0, 5'b11100, 2'b00, 2'b00, 2'b11, 1'b1, 16'd1, "mw_in_flush_2");
    chk(v, 0, 5'b11100, 2'b00, 2'b00, 2'b11, 1'b1, 16'd2, "mw_in_flush_3");
    v = idle(); v.rmm = 1; v.mr = 1;
    chk(v, 0, 5'b00011, 2'b00, 2'b00, 2'b11, 1'b1, 16'd3, "mw_resume_flush");
    chk(idle(), 0, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b1, 16'd3, "mw_flush_done");

    // Redirect and load-use together in RUN: flush wins
    do_reset(0);
    v = idle(); v.jp = 2'b01; v.rme = 1; v.wre = 1; v.a3e = 3; v.rs = 3; v.urs = 1;
    chk(v, 0, 5'b00011, 2'b00, 2'b00, 2'b00, 1'b0, 16'd0, "redir_over_luse");
    chk(idle(), 0, 5'b00011, 2'b00, 2'b00, 2'b01, 1'b1, 16'd0, "redir_over_luse_c2");

    // LU_BUBBLES=3: redirect inside LU_STALL enters FLUSH
    do_reset(1);
    v = idle(); v.rme = 1; v.wre = 1; v.a3e = 4; v.rt = 4; v.urt = 1;
    chk(v, 1, 5'b11001, 2'b00, 2'b00, 2'b00, 1'b0, 16'd0, "lu3_c1");
    chk(idle(), 1, 5'b11001, 2'b00, 2'b00, 2'b10, 1'b0, 16'd0, "lu3_c2");
    v = idle(); v.jp = 2'b01;
    chk(v, 1, 5'b00011, 2'b00, 2'b00, 2'b10, 1'b0, 16'd0, "lu3_redirect");
    chk(idle(), 1, 5'b00011, 2'b00, 2'b00, 2'b01, 1'b1, 16'd2, "lu3_redirect_flush");
    chk(idle(), 1, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b0, 16'd0, "lu3_redirect_done");

    // LU_BUBBLES=3: full run of three bubbles
    do_reset(1);
    v = idle(); v.rme = 1; v.wre = 1; v.a3e = 4; v.rs = 4; v.urs = 1;
    chk(v, 1, 5'b11001, 2'b00, 2'b00, 2'b00, 1'b0, 16'd0, "lu3_full_c1");
    chk(idle(), 1, 5'b11001, 2'b00, 2'b00, 2'b10, 1'b0, 16'd0, "lu3_full_c2");
    chk(idle(), 1, 5'b11001, 2'b00, 2'b00, 2'b10, 1'b0, 16'd0, "lu3_full_c3");
    chk(idle(), 1, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b1, 16'd3, "lu3_full_done");

    // Reset in the middle of LU_STALL abandons the sequence
    do_reset(1);
    v = idle(); v.rme = 1; v.wre = 1; v.a3e = 4; v.rs = 4; v.urs = 1;
    chk(v, 1, 5'b11001, 2'b00, 2'b00, 2'b00, 1'b0, 16'd0, "lu3_rst_c1");
    v = idle(); v.rst = 1; v.a3m = 2; v.wrm = 1; v.rs = 2; v.urs = 1; v.rmm = 1; v.mr = 0;
    chk(v, 1, 5'b00000, 2'b00, 2'b00, 2'b10, 1'b0, 16'd0, "rst_quiets_outputs");
    chk(idle(), 1, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b1, 16'd0, "rst_back_to_run");

    // Saturation of the stall counter over 2^16+5 wait cycles
    do_reset(0);
    v = idle(); v.rmm = 1; v.mr = 0;
    for (int i = 0; i < 65541; i++) begin
      if (i == 65534)
        chk(v, 0, 5'b11100, 2'b00, 2'b00, 2'b11, 1'b1, 16'hFFFE, "sc_fffe");
      else if (i == 65535)
        chk(v, 0, 5'b11100, 2'b00, 2'b00, 2'b11, 1'b1, 16'hFFFF, "sc_ffff");
      else if (i == 65540)
        chk(v, 0, 5'b11100, 2'b00, 2'b00, 2'b11, 1'b1, 16'hFFFF, "sc_saturated");
      else
        drive(v);
    end
    chk(idle(), 0, 5'b00000, 2'b00, 2'b00, 2'b11, 1'b1, 16'hFFFF, "sc_hold_mw_exit");
    chk(idle(), 0, 5'b00000, 2'b00, 2'b00, 2'b00, 1'b1, 16'hFFFF, "sc_hold_run");

    repeat (2) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Feedback-side control for the 5-stage pipeline. Consumes destination and control fields already registered in EX and MEM, plus the source-register addresses being decoded in ID.
- Drives stall, flush and bubble-insert commands back into PC, IF/ID and ID/EX, and forwarding selects for the EX-stage ALU operand muxes.
- Holds a small FSM for multi-cycle redirect flushes, load-use bubbles and data-memory wait freezes. Also holds a saturating stall counter for performance debug.

Parameters:
- REG_AW, 3, register address width
- FLUSH_CYCLES, 2, number of cycles IF/ID and ID/EX are flushed on a taken jump/branch (1..7)
- LU_BUBBLES, 1, bubbles inserted on a load-use hazard (1..3)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rs_addr_ID  in  REG_AW  ALU operand A source register in ID
- rt_addr_ID  in  REG_AW  operand B / store-data source register in ID
- use_rs_ID  in  1  ID instruction reads rs
- use_rt_ID  in  1  ID instruction reads rt
- addr3_EX  in  REG_AW  EX destination register
- wite_reg_EX  in  1  EX writes register file
- read_mem_EX  in  1  EX is a load
- jp_flag_EX  in  2  00 none, 01 unconditional jump, 10 conditional branch, 11 reserved (treated as 00)
- branch_taken_EX  in  1  condition result for jp_flag_EX=10
- addr3_MEM  in  REG_AW  MEM destination register
- wite_reg_MEM  in  1  MEM writes register file
- read_mem_MEM  in  1  MEM is a load
- mem_ready  in  1  data memory has returned/accepted this cycle
- stall_PC  out  1  hold PC
- stall_IFID  out  1  hold IF/ID
- stall_IDEX  out  1  hold ID/EX
- flush_IFID  out  1  clear IF/ID to NOP next edge
- flush_IDEX  out  1  load ID/EX with bubble (all write/mem/jp controls 0) next edge
- fwd_a_sel  out  2  00 regfile, 01 from EX result, 10 from MEM result
- fwd_b_sel  out  2  same encoding, for rt
- hz_state  out  2  current FSM state (debug)
- stall_cnt  out  CNT_W  cycles with stall_PC=1, saturating

Behaviour:
- Hazard conditions:
  - Hazards on register 0 ignored: any address equal to 0 never matches.
  - redirect = (jp_flag_EX==01) | (jp_flag_EX==10 & branch_taken_EX)
  - luse = read_mem_EX & wite_reg_EX & ((use_rs_ID & rs_addr_ID==addr3_EX) | (use_rt_ID & rt_addr_ID==addr3_EX))
  - mwait = read_mem_MEM & !mem_ready
- FSM states: RUN=00, FLUSH=01, LU_STALL=10, MEM_WAIT=11. A down-counter cnt (3 bits) is used in FLUSH and LU_STALL.
- Control outputs are combinational from state and current inputs. Priority in every state: mwait > redirect > luse.
- mwait (any state):
  - stall_PC=stall_IFID=stall_IDEX=1; flushes 0.
  - Next state MEM_WAIT; prior state and cnt are saved and resumed when mwait drops.
- RUN:
  - redirect: flush_IFID=flush_IDEX=1. If FLUSH_CYCLES>1, go FLUSH with cnt=FLUSH_CYCLES-1; otherwise stay in RUN.
  - luse: stall_PC=stall_IFID=1, flush_IDEX=1. If LU_BUBBLES>1, go LU_STALL with cnt=LU_BUBBLES-1.
  - Otherwise all control outputs 0.
- FLUSH: flush_IFID=flush_IDEX=1 each cycle; cnt decrements; return to RUN when cnt reaches 0.
  - redirect is not re-evaluated here, because EX holds bubbles.
- LU_STALL: same outputs as luse in RUN; cnt decrements; return to RUN at 0.
  - A redirect arriving here takes priority and enters FLUSH.
- MEM_WAIT: while mwait, freeze; on mem_ready=1, output for that cycle is per the saved state and next state restores it.
- Forwarding:
  - fwd_a_sel=01 if wite_reg_EX & !read_mem_EX & addr3_EX==rs_addr_ID & rs_addr_ID!=0.
  - Else 10 if wite_reg_MEM & addr3_MEM==rs_addr_ID & rs_addr_ID!=0.
  - Else 00. fwd_b_sel uses rt_addr_ID the same way.
  - EX has priority over MEM. Forwarding is valid in all states.
- stall_cnt increments on each cycle with stall_PC=1 and sticks at all-ones.
- Reset:
  - While reset=1, all control outputs and fwd selects are 0.
  - On the edge, state=RUN, cnt=0, saved state cleared, stall_cnt=0.
  - Reset mid-FLUSH/LU_STALL/MEM_WAIT abandons the sequence; first cycle after reset is RUN.
- No internal latency beyond FSM: a hazard visible at cycle N produces outputs in cycle N.

Test Plan:
- Load r3 in EX (read_mem_EX=1, wite_reg_EX=1, addr3_EX=3), ID reads rs=3, LU_BUBBLES=1 -> one cycle stall_PC=stall_IFID=flush_IDEX=1; next cycle addr3_MEM=3 gives fwd_a_sel=10, stall 0, stall_cnt=1.
- jp_flag_EX=10, branch_taken_EX=1, FLUSH_CYCLES=2 -> flush_IFID=flush_IDEX=1 for 2 consecutive cycles, hz_state 00->01->00. With branch_taken_EX=0 -> no flush.
- ALU write r5 in EX and load write r5 in MEM, ID rt=5, use_rt_ID=1 -> fwd_b_sel=01. Same case with addr3=0 and rt=0 -> fwd_b_sel=00, no stall.
- read_mem_MEM=1, mem_ready=0 for 3 cycles during FLUSH with cnt=1 -> 3 cycles all stalls 1, no flush; on mem_ready=1, FLUSH resumes and completes its remaining cycle.
- Simultaneous redirect and luse in RUN -> only flush behaviour (stall_PC=0), hz_state=01.
- Assert reset in LU_STALL with LU_BUBBLES=3 after 1 bubble -> outputs 0 during reset, state RUN and stall_cnt=0 after; 2^CNT_W+5 forced stall cycles -> stall_cnt saturates at 0xFFFF.
